// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: shares the vga_adapter pixel-write port between the shape
// drawer (requester 0) and the cursor drawer (requester 1), with a built-in
// full-screen clear sweep that takes absolute priority over both.
module vga_write_arbiter #(
    parameter int unsigned X_MAX        = 160,
    parameter int unsigned Y_MAX        = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear_start,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [2:0] c0,
    input  logic [2:0] c1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       clear_done
);

    typedef enum logic {RUN, CLEAR} state_t;

    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [7:0] Y_LIM = 8'(Y_MAX);
    localparam logic [7:0] X_END = 8'(X_MAX - 1);
    localparam logic [6:0] Y_END = 7'(Y_MAX - 1);

    state_t     state;
    logic       prio;
    logic [7:0] cx;
    logic [6:0] cy;
    logic       sweep_last;

    logic       run_ok;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_c;
    logic       sel_in_range;

    // Grant decision and selection of the granted requester's pixel.
    always_comb begin
        run_ok       = resetn && (state == RUN) && !clear_start;
        gnt0         = run_ok && req0 && (!req1 || !prio);
        gnt1         = run_ok && req1 && (!req0 || prio);
        sel_x        = gnt1 ? x1 : x0;
        sel_y        = gnt1 ? y1 : y0;
        sel_c        = gnt1 ? c1 : c0;
        sel_in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
    end

    assign busy = (state == CLEAR);

    // Arbitration state, clear sweep counters and the registered write port.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= RUN;
            prio       <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            sweep_last <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            vga_plot   <= 1'b0;
            case (state)
                RUN: begin
                    if (clear_start) begin
                        state <= CLEAR;
                    end else if (gnt0 || gnt1) begin
                        vga_x      <= sel_x;
                        vga_y      <= sel_y;
                        vga_colour <= sel_c;
                        vga_plot   <= sel_in_range;
                        prio       <= gnt0;
                    end
                end
                CLEAR: begin
                    // The last pixel is written one edge before busy drops, so one
                    // extra CLEAR cycle (sweep_last) separates it from clear_done.
                    if (sweep_last) begin
                        state      <= RUN;
                        sweep_last <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        vga_x      <= cx;
                        vga_y      <= cy;
                        vga_colour <= CLEAR_COLOUR;
                        vga_plot   <= 1'b1;
                        if (cx == X_END) begin
                            cx <= '0;
                            if (cy == Y_END) begin
                                cy         <= '0;
                                sweep_last <= 1'b1;
                            end else begin
                                cy <= cy + 7'd1;
                            end
                        end else begin
                            cx <= cx + 8'd1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench for vga_write_arbiter: directed scenarios plus a
// randomized request stream checked against a behavioural arbitration model.
module tb_vga_write_arbiter;

    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;
    localparam int NPIX  = X_MAX * Y_MAX;

    logic       clock = 1'b0;
    logic       resetn, clear_start, req0, req1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] c0, c1;
    logic       gnt0, gnt1, vga_plot, busy, clear_done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    vga_write_arbiter #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .CLEAR_COLOUR(3'b000)) dut (
        .clock(clock), .resetn(resetn), .clear_start(clear_start),
        .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .c0(c0), .c1(c1), .gnt0(gnt0), .gnt1(gnt1),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .clear_done(clear_done)
    );

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic apply_reset();
        resetn = 0; clear_start = 0; req0 = 0; req1 = 0;
        repeat (2) @(posedge clock);
        #1 resetn = 1;
    endtask

    task automatic test_reset();
        clear_start = 0; req0 = 1; req1 = 1;
        x0 = 8'd10; y0 = 7'd20; c0 = 3'd5; x1 = 8'd30; y1 = 7'd40; c1 = 3'd2;
        resetn = 0;
        repeat (2) @(posedge clock);
        #2;
        vectors++;
        if ({vga_x, vga_y, vga_colour, vga_plot, busy, clear_done, gnt0, gnt1} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {vga_x, vga_y, vga_colour, vga_plot, busy, clear_done, gnt0, gnt1});
        end
        resetn = 1; #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL reset_first_grant got=%b exp=10", {gnt0, gnt1});
        end
        @(posedge clock); #1;
        vectors++;
        if ({vga_x, vga_y, vga_colour, vga_plot} !== {8'd10, 7'd20, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_write got=%h exp=%h", {vga_x, vga_y, vga_colour, vga_plot},
                     {8'd10, 7'd20, 3'd5, 1'b1});
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_contention();
        apply_reset();
        x0 = 8'd11; y0 = 7'd1; c0 = 3'd1; x1 = 8'd22; y1 = 7'd2; c1 = 3'd6;
        req0 = 1; req1 = 1; #1;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL contention_gnt[%0d] got=%b", i, {gnt0, gnt1});
            end
            @(posedge clock); #1;
            vectors++;
            if ({vga_x, vga_colour, vga_plot} !==
                ((i % 2 == 0) ? {8'd11, 3'd1, 1'b1} : {8'd22, 3'd6, 1'b1})) begin
                errors++;
                $display("FAIL contention_write[%0d] got=%h", i, {vga_x, vga_colour, vga_plot});
            end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_single();
        apply_reset();
        x1 = 8'd77; y1 = 7'd66; c1 = 3'd4; req1 = 1; #1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({gnt0, gnt1} !== 2'b01) begin
                errors++; $display("FAIL single1_gnt[%0d] got=%b exp=01", i, {gnt0, gnt1});
            end
            @(posedge clock); #1;
            vectors++;
            if ({vga_x, vga_y, vga_colour, vga_plot} !== {8'd77, 7'd66, 3'd4, 1'b1}) begin
                errors++; $display("FAIL single1_write[%0d] got=%h", i, {vga_x, vga_y, vga_colour, vga_plot});
            end
        end
        req1 = 0; x0 = 8'd159; y0 = 7'd119; c0 = 3'd7; req0 = 1; #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL single0_gnt got=%b exp=10", {gnt0, gnt1});
        end
        @(posedge clock); #1;
        vectors++;
        if ({vga_x, vga_y, vga_colour, vga_plot} !== {8'd159, 7'd119, 3'd7, 1'b1}) begin
            errors++; $display("FAIL single0_write got=%h", {vga_x, vga_y, vga_colour, vga_plot});
        end
        req0 = 0;
    endtask

    task automatic test_clear_sweep();
        apply_reset();
        x0 = 8'd33; y0 = 7'd44; c0 = 3'd3; x1 = 8'd55; y1 = 7'd66; c1 = 3'd2;
        req0 = 1; req1 = 1; clear_start = 1; #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++; $display("FAIL clear_start_gnt got=%b exp=00", {gnt0, gnt1});
        end
        @(posedge clock); #1;
        clear_start = 0;
        vectors++;
        if ({busy, vga_plot, clear_done} !== 3'b100) begin
            errors++; $display("FAIL clear_enter got=%b exp=100", {busy, vga_plot, clear_done});
        end
        for (int k = 0; k < NPIX; k++) begin
            @(posedge clock); #1;
            clear_start = (k == 500);
            vectors++;
            if ({vga_x, vga_y, vga_colour, vga_plot, busy, clear_done, gnt0, gnt1} !==
                {8'(k % X_MAX), 7'(k / X_MAX), 3'd0, 1'b1, 1'b1, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL clear_pixel[%0d] got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b gnt=%b",
                         k, vga_x, vga_y, vga_colour, vga_plot, busy, clear_done, {gnt0, gnt1});
            end
        end
        @(posedge clock); #1;
        vectors++;
        if ({busy, clear_done, vga_plot, gnt0, gnt1} !== 5'b01010) begin
            errors++;
            $display("FAIL clear_done_cycle got=%b exp=01010", {busy, clear_done, vga_plot, gnt0, gnt1});
        end
        @(posedge clock); #1;
        vectors++;
        if ({clear_done, vga_x, vga_y, vga_colour, vga_plot} !== {1'b0, 8'd33, 7'd44, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL clear_after_write got=%h", {clear_done, vga_x, vga_y, vga_colour, vga_plot});
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_range_and_midreset();
        apply_reset();
        x0 = 8'd200; y0 = 7'd10; c0 = 3'd7; req0 = 1; #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            errors++; $display("FAIL oor_x_gnt got=%b exp=1", gnt0);
        end
        @(posedge clock); #1;
        vectors++;
        if ({vga_x, vga_y, vga_plot} !== {8'd200, 7'd10, 1'b0}) begin
            errors++; $display("FAIL oor_x_write got=%h", {vga_x, vga_y, vga_plot});
        end
        x0 = 8'd5; y0 = 7'd120; #1;
        @(posedge clock); #1;
        vectors++;
        if ({vga_x, vga_y, vga_plot} !== {8'd5, 7'd120, 1'b0}) begin
            errors++; $display("FAIL oor_y_write got=%h", {vga_x, vga_y, vga_plot});
        end
        req0 = 0; clear_start = 1;
        @(posedge clock); #1;
        clear_start = 0;
        repeat (1000) @(posedge clock);
        #1 resetn = 0; #1;
        vectors++;
        if ({busy, clear_done, vga_plot, vga_x, vga_y} !== 18'h0) begin
            errors++; $display("FAIL midreset_outputs got=%h exp=0", {busy, clear_done, vga_plot, vga_x, vga_y});
        end
        #1 resetn = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            vectors++;
            if ({busy, clear_done} !== 2'b00) begin
                errors++; $display("FAIL midreset_idle[%0d] got=%b exp=00", i, {busy, clear_done});
            end
        end
        clear_start = 1;
        @(posedge clock); #1;
        clear_start = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            vectors++;
            if ({vga_x, vga_y, vga_plot, busy} !== {8'(k), 7'd0, 1'b1, 1'b1}) begin
                errors++; $display("FAIL restart_pixel[%0d] got=%h", k, {vga_x, vga_y, vga_plot, busy});
            end
        end
    endtask

    // Behavioural model: each requester holds one pending pixel until served;
    // contested cycles go to whichever requester was not served most recently.
    task automatic test_random();
        logic [7:0] px[2];
        logic [6:0] py[2];
        logic [2:0] pc[2];
        bit         pend[2];
        int         last_winner;
        int         w;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        logic       ep;
        apply_reset();
        pend[0] = 0; pend[1] = 0; last_winner = 1;
        ex = 0; ey = 0; ec = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0) begin
                    pend[r] = 1;
                    px[r] = 8'($urandom_range(0, 199));
                    py[r] = 7'($urandom_range(0, 127));
                    pc[r] = 3'($urandom_range(0, 7));
                end
            end
            req0 = pend[0]; x0 = px[0]; y0 = py[0]; c0 = pc[0];
            req1 = pend[1]; x1 = px[1]; y1 = py[1]; c1 = pc[1];
            #1;
            if (pend[0] && pend[1]) w = 1 - last_winner;
            else if (pend[0])       w = 0;
            else if (pend[1])       w = 1;
            else                    w = -1;
            vectors++;
            if ({gnt0, gnt1} !== {w == 0, w == 1}) begin
                errors++; $display("FAIL random_gnt[%0d] got=%b exp=%b", n, {gnt0, gnt1}, {w == 0, w == 1});
            end
            @(posedge clock); #1;
            ep = 0;
            if (w >= 0) begin
                ex = px[w]; ey = py[w]; ec = pc[w];
                ep = (int'(px[w]) < X_MAX) && (int'(py[w]) < Y_MAX);
                pend[w] = 0;
                last_winner = w;
            end
            vectors++;
            if ({vga_x, vga_y, vga_colour, vga_plot} !== {ex, ey, ec, ep}) begin
                errors++;
                $display("FAIL random_write[%0d] got=%h exp=%h", n,
                         {vga_x, vga_y, vga_colour, vga_plot}, {ex, ey, ec, ep});
            end
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        resetn = 0; clear_start = 0; req0 = 0; req1 = 0;
        x0 = 0; x1 = 0; y0 = 0; y1 = 0; c0 = 0; c1 = 0;
        test_reset();
        test_contention();
        test_single();
        test_clear_sweep();
        test_range_and_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
